// File: rtl/cpu_io_port_gen_if.sv
// CPU-side register bus plus port pins of the generic CPU I/O port.
// The CPU shell drives the master side; the port block is the slave.
interface cpu_io_port_gen_if;
  logic        enable;
  logic [15:0] address;
  logic        we;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        hit;
  logic [7:0]  port_in;
  logic [7:0]  port_out;
  logic [7:0]  port_dir;
  logic        irq_n;

  modport master (
    output enable, address, we, wdata, port_in,
    input  rdata, hit, port_out, port_dir, irq_n
  );

  modport slave (
    input  enable, address, we, wdata, port_in,
    output rdata, hit, port_out, port_dir, irq_n
  );
endinterface

// File: rtl/cpu_io_port_gen.sv
// 4-register CPU I/O port (DDR/DATA/IFR/IMR): combinational read, writes and irq_n
// registered on enable ticks; no backpressure, every access completes in one cycle.
module cpu_io_port_gen #(
  parameter int          WIDTH       = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [7:0]  FADE_MASK   = 8'hC0,
  parameter logic [19:0] FADE_CYCLES = 20'd350000,
  parameter int          IRQ_EN      = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_io_port_gen_if.slave  bus
);

  localparam logic [8:0] W_ONE    = 9'(1 << WIDTH);
  localparam logic [7:0] W_MASK   = W_ONE[7:0] - 8'd1;
  localparam logic [7:0] W_FADE   = FADE_MASK & W_MASK;
  localparam logic [7:0] IRQ_MASK = (IRQ_EN != 0) ? W_MASK : 8'h00;

  logic [7:0]  r_ddr, r_data, r_ifr, r_imr, r_ret, r_prev;
  logic [19:0] r_cnt;
  logic        r_irq_n;

  logic        w_hit, w_wr;
  logic [1:0]  w_off;
  logic [7:0]  w_wdat, w_fading, w_pin_eff, w_fall, w_fade_chg, w_ifr_clr, w_rdata;

  assign w_hit  = (bus.address[15:2] == BASE_ADDR[15:2]);
  assign w_off  = bus.address[1:0];
  assign w_wr   = bus.enable & w_hit & bus.we;
  assign w_wdat = bus.wdata & W_MASK;

  // Undriven fade bits keep showing the value they had as outputs until the counter expires.
  assign w_fading  = (r_cnt != 20'd0) ? (W_FADE & ~r_ddr) : 8'h00;
  assign w_pin_eff = (bus.port_in & ~w_fading) | (r_ret & w_fading);

  // Edge qualifier uses the DDR value before any same-cycle write.
  assign w_fall     = r_prev & ~bus.port_in & ~r_ddr & W_MASK;
  assign w_fade_chg = (w_wr && w_off == 2'd0) ? (r_ddr & ~w_wdat & W_FADE) : 8'h00;
  assign w_ifr_clr  = (w_wr && w_off == 2'd2) ? w_wdat : 8'h00;

  always_comb begin
    w_rdata = 8'h00;
    if (w_hit) begin
      case (w_off)
        2'd0:    w_rdata = r_ddr;
        2'd1:    w_rdata = ((r_ddr & r_data) | (~r_ddr & w_pin_eff)) & W_MASK;
        2'd2:    w_rdata = r_ifr;
        default: w_rdata = r_imr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ddr   <= 8'h00;
      r_data  <= 8'h00;
      r_ifr   <= 8'h00;
      r_imr   <= 8'h00;
      r_ret   <= 8'h00;
      r_prev  <= 8'h00;
      r_cnt   <= 20'd0;
      r_irq_n <= 1'b1;
    end else if (bus.enable) begin
      r_prev  <= bus.port_in;
      // A new edge wins over a same-cycle write-1-clear.
      r_ifr   <= ((r_ifr & ~w_ifr_clr) | w_fall) & IRQ_MASK;
      r_irq_n <= ~|(r_ifr & r_imr);
      if (w_fade_chg != 8'h00) begin
        r_ret <= (r_ret & ~w_fade_chg) | (r_data & w_fade_chg);
        r_cnt <= FADE_CYCLES;
      end else if (r_cnt != 20'd0) begin
        r_cnt <= r_cnt - 20'd1;
      end
      if (w_wr) begin
        case (w_off)
          2'd0:    r_ddr  <= w_wdat;
          2'd1:    r_data <= w_wdat;
          2'd3:    r_imr  <= w_wdat & IRQ_MASK;
          default: ;
        endcase
      end
    end
  end

  assign bus.rdata    = w_rdata;
  assign bus.hit      = w_hit;
  assign bus.port_out = r_data;
  assign bus.port_dir = r_ddr;
  assign bus.irq_n    = r_irq_n;

endmodule

// File: tb/tb_cpu_io_port_gen.sv
// Bench for cpu_io_port_gen: two instances (8-bit at 0000, 6-bit at FD10) against a behavioural model.
module tb_cpu_io_port_gen;

  localparam int         FC = 4;
  localparam logic [7:0] FM = 8'hC0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, en = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wd = 8'h00, pin = 8'h00;
  logic        chk_en = 1'b0;
  int          n_vec = 0, n_err = 0;

  cpu_io_port_gen_if if0 ();
  cpu_io_port_gen_if if1 ();

  assign if0.enable  = en;
  assign if0.address = addr;
  assign if0.we      = we;
  assign if0.wdata   = wd;
  assign if0.port_in = pin;
  assign if1.enable  = en;
  assign if1.address = addr ^ 16'hFD10;
  assign if1.we      = we;
  assign if1.wdata   = wd;
  assign if1.port_in = pin;

  cpu_io_port_gen #(.WIDTH(8), .BASE_ADDR(16'h0000), .FADE_MASK(FM),
                    .FADE_CYCLES(20'(FC)), .IRQ_EN(1))
    dut0 (.clk(clk), .reset_n(rst_n), .bus(if0.slave));
  cpu_io_port_gen #(.WIDTH(6), .BASE_ADDR(16'hFD10), .FADE_MASK(FM),
                    .FADE_CYCLES(20'(FC)), .IRQ_EN(1))
    dut1 (.clk(clk), .reset_n(rst_n), .bus(if1.slave));

  logic [7:0] o_rdata[2], o_pout[2], o_pdir[2];
  logic       o_hit[2], o_irqn[2];
  assign o_rdata[0] = if0.rdata;    assign o_rdata[1] = if1.rdata;
  assign o_pout[0]  = if0.port_out; assign o_pout[1]  = if1.port_out;
  assign o_pdir[0]  = if0.port_dir; assign o_pdir[1]  = if1.port_dir;
  assign o_hit[0]   = if0.hit;      assign o_hit[1]   = if1.hit;
  assign o_irqn[0]  = if0.irq_n;    assign o_irqn[1]  = if1.irq_n;

  // Behavioural model state, one slot per instance.
  logic [7:0]  m_ddr[2], m_data[2], m_ifr[2], m_imr[2], m_ret[2], m_prev[2];
  int          m_cnt[2];
  logic        m_irqn[2];
  logic [7:0]  wmask[2] = '{8'hFF, 8'h3F};
  logic [15:0] base[2]  = '{16'h0000, 16'hFD10};

  function automatic logic [15:0] a_of(int d);
    return (d == 0) ? addr : (addr ^ 16'hFD10);
  endfunction

  function automatic logic m_hit(int d);
    logic [15:0] a, b;
    a = a_of(d);
    b = base[d];
    return a[15:2] == b[15:2];
  endfunction

  function automatic logic [7:0] m_rdata(int d);
    logic [15:0] a;
    logic [7:0]  fb, pe;
    a = a_of(d);
    if (!m_hit(d)) return 8'h00;
    case (a[1:0])
      2'd0: return m_ddr[d];
      2'd2: return m_ifr[d];
      2'd3: return m_imr[d];
      default: begin
        fb = (m_cnt[d] > 0) ? (FM & wmask[d] & ~m_ddr[d]) : 8'h00;
        pe = (pin & ~fb) | (m_ret[d] & fb);
        return ((m_ddr[d] & m_data[d]) | (~m_ddr[d] & pe)) & wmask[d];
      end
    endcase
  endfunction

  task automatic m_step(int d);
    logic [15:0] a;
    logic [7:0]  w, fall, chg, nifr;
    logic        wr;
    a = a_of(d);
    if (!rst_n) begin
      m_ddr[d] = 0; m_data[d] = 0; m_ifr[d] = 0; m_imr[d] = 0;
      m_ret[d] = 0; m_prev[d] = 0; m_cnt[d] = 0; m_irqn[d] = 1'b1;
      return;
    end
    if (!en) return;
    wr   = m_hit(d) && we;
    w    = wd & wmask[d];
    fall = m_prev[d] & ~pin & ~m_ddr[d] & wmask[d];
    nifr = m_ifr[d];
    if (wr && a[1:0] == 2'd2) nifr = nifr & ~w;
    nifr = nifr | fall;
    m_irqn[d] = ((m_ifr[d] & m_imr[d]) == 8'h00);
    chg = (wr && a[1:0] == 2'd0) ? (m_ddr[d] & ~w & FM & wmask[d]) : 8'h00;
    if (chg != 0) begin
      m_ret[d] = (m_ret[d] & ~chg) | (m_data[d] & chg);
      m_cnt[d] = FC;
    end else if (m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
    if (wr && a[1:0] == 2'd0) m_ddr[d]  = w;
    if (wr && a[1:0] == 2'd1) m_data[d] = w;
    if (wr && a[1:0] == 2'd3) m_imr[d]  = w;
    m_ifr[d]  = nifr;
    m_prev[d] = pin;
  endtask

  always @(posedge clk) begin
    m_step(0);
    m_step(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, mid-way between drive and next active edge.
  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rdata%0d", d), o_rdata[d], m_rdata(d));
        chk($sformatf("hit%0d", d), {7'd0, o_hit[d]}, {7'd0, m_hit(d)});
        chk($sformatf("port_out%0d", d), o_pout[d], m_data[d]);
        chk($sformatf("port_dir%0d", d), o_pdir[d], m_ddr[d]);
        chk($sformatf("irq_n%0d", d), {7'd0, o_irqn[d]}, {7'd0, m_irqn[d]});
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic [15:0] a, input logic w,
                     input logic [7:0] d, input logic [7:0] p);
    @(negedge clk);
    rst_n = r; en = e; addr = a; we = w; wd = d; pin = p;
    #3;
  endtask

  logic [15:0] hit_addr[8] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003,
                               16'h0004, 16'h001F, 16'hFFFF, 16'h0100};
  logic [7:0]  hit_exp[8]  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    // Reset, then all pins are inputs.
    cyc(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 8'h5A);
    cyc(1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 8'h5A);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 16'h0001, 1'b0, 8'h00, 8'h5A);
    chk("rst_dir", if0.port_dir, 8'h00);
    chk("rst_out", if0.port_out, 8'h00);
    chk("rst_irqn", {7'd0, if0.irq_n}, 8'h01);
    chk("rst_rd", if0.rdata, 8'h5A);
    chk("rst_rd_w6", if1.rdata, 8'h1A);

    // Mixed direction read.
    cyc(1'b1, 1'b1, 16'h0000, 1'b1, 8'h0F, 8'hA0);
    cyc(1'b1, 1'b1, 16'h0001, 1'b1, 8'h35, 8'hA0);
    cyc(1'b1, 1'b1, 16'h0001, 1'b0, 8'h00, 8'hA0);
    chk("mix_out", if0.port_out, 8'h35);
    chk("mix_rd", if0.rdata, 8'hA5);
    chk("mix_rd_w6", if1.rdata, 8'h25);
    cyc(1'b1, 1'b1, 16'h0004, 1'b0, 8'h00, 8'hA0);
    chk("miss_hit", {7'd0, if0.hit}, 8'h00);
    chk("miss_rd", if0.rdata, 8'h00);

    // Fade: outputs C0 released to inputs with pins low.
    cyc(1'b1, 1'b1, 16'h0000, 1'b1, 8'hC0, 8'h00);
    cyc(1'b1, 1'b1, 16'h0001, 1'b1, 8'hC0, 8'h00);
    cyc(1'b1, 1'b1, 16'h0000, 1'b1, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 16'h0001, 1'b0, 8'h00, 8'h00);
    chk("fade_t1", if0.rdata, 8'hC0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 16'h0001, 1'b0, 8'h00, 8'h00);
      chk("fade_frozen", if0.rdata, 8'hC0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 16'h0001, 1'b0, 8'h00, 8'h00);
      chk("fade_hold", if0.rdata, 8'hC0);
    end
    cyc(1'b1, 1'b1, 16'h0001, 1'b0, 8'h00, 8'h00);
    chk("fade_done", if0.rdata, 8'h00);

    // Falling-edge interrupt and clear.
    cyc(1'b1, 1'b1, 16'h0002, 1'b1, 8'hFF, 8'h00);
    cyc(1'b1, 1'b1, 16'h0003, 1'b1, 8'h01, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h01);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    chk("irq_ifr", if0.rdata, 8'h01);
    chk("irq_lat", {7'd0, if0.irq_n}, 8'h01);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    chk("irq_set", {7'd0, if0.irq_n}, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b1, 8'h01, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    chk("clr_ifr", if0.rdata, 8'h00);
    chk("clr_lat", {7'd0, if0.irq_n}, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    chk("clr_irq", {7'd0, if0.irq_n}, 8'h01);

    // Clear colliding with a new edge: set wins.
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h01);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h01);
    cyc(1'b1, 1'b1, 16'h0002, 1'b1, 8'h01, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    chk("race_ifr", if0.rdata, 8'h01);
    chk("race_irq", {7'd0, if0.irq_n}, 8'h00);
    cyc(1'b1, 1'b1, 16'h0002, 1'b0, 8'h00, 8'h00);
    chk("race_irq2", {7'd0, if0.irq_n}, 8'h00);

    // Width masking and window decode on the 6-bit instance at FD10.
    cyc(1'b1, 1'b1, 16'h0000, 1'b1, 8'hFF, 8'h00);
    cyc(1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 8'h00);
    chk("w6_dir", if1.port_dir, 8'h3F);
    chk("w6_rd", if1.rdata, 8'h3F);
    chk("w8_dir", if0.port_dir, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, hit_addr[i], 1'b0, 8'h00, 8'h00);
      chk($sformatf("w6_hit_%h", if1.address), {7'd0, if1.hit}, hit_exp[i]);
    end

    // Randomised traffic, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      logic        r, e, w;
      logic [15:0] a;
      logic [7:0]  d, p;
      r = ($urandom_range(0, 99) != 0);
      e = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 7) != 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      w = ($urandom_range(0, 1) != 0);
      d = 8'($urandom);
      p = pin;
      if ($urandom_range(0, 2) == 0) p = p ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) p = 8'($urandom);
      cyc(r, e, a, w, d, p);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
